// File: rtl/hgcal_latent_rx.sv
// hgcal_latent_rx
// Receive side of the HGCAL autoencoder latent link. Narrow link words, framed
// by a start-of-frame marker, are reassembled into one full-width latent vector
// for the decoder LUT network. A collection buffer plus an output register give
// two frames of buffering. Once both are full, s_ready drops.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   link word valid
//   s_ready    out  link word accepted when s_valid && s_ready at a rising edge
//   s_data     in   link word [LINK_W]; code i sits at [i*CODE_W +: CODE_W]
//   s_sof      in   marks word 0 of a frame (qualified by s_valid)
//   m_valid    out  latent vector valid
//   m_ready    in   decoder accepts the vector
//   m_latent   out  latent vector; word k sits at [k*LINK_W +: LINK_W]
//   err_sync   out  one-cycle pulse per sync error
//   err_cnt    out  saturating sync-error count
//   frame_cnt  out  wrapping count of vectors handed to the decoder
module hgcal_latent_rx #(
  parameter int LATENT_N = 16,
  parameter int CODE_W   = 2,
  parameter int LINK_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LINK_W-1:0]          s_data,
  input  logic                       s_sof,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [LATENT_N*CODE_W-1:0] m_latent,
  output logic                       err_sync,
  output logic [7:0]                 err_cnt,
  output logic [15:0]                frame_cnt
);

  localparam int VEC_W = LATENT_N * CODE_W;
  localparam int WORDS = VEC_W / LINK_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic [LINK_W-1:0]  r_buf [WORDS];
  logic               r_m_valid;
  logic [VEC_W-1:0]   r_m_latent;
  logic               r_err_sync;
  logic [7:0]         r_err_cnt;
  logic [15:0]        r_frame_cnt;

  logic               w_accept;
  logic               w_out_free;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_slot;
  logic               w_err;
  logic               w_complete;
  logic               w_load;
  logic [WORDS-1:0]   w_hit;
  logic [VEC_W-1:0]   w_frame;

  assign s_ready    = (r_state != ST_HOLD);
  assign w_accept   = s_valid && s_ready;
  assign w_out_free = !r_m_valid || m_ready;

  // The frame image fed to the output register bypasses the word being
  // written this cycle, so a completing frame loads with zero extra latency.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
    assign w_hit[gi] = w_wr_en && (w_wr_slot == IDX_W'(gi));
    assign w_frame[gi*LINK_W +: LINK_W] = w_hit[gi] ? s_data : r_buf[gi];
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_wr_en      = 1'b0;
    w_wr_slot    = '0;
    w_err        = 1'b0;
    w_complete   = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (w_accept) begin
          if (s_sof) begin
            w_wr_en      = 1'b1;
            w_idx_next   = IDX_W'(1);
            w_complete   = (WORDS == 1);
            w_state_next = ST_COLLECT;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (s_sof) begin
            // Resynchronise on the new frame; the partial one is dropped.
            w_err      = 1'b1;
            w_wr_slot  = '0;
            w_idx_next = IDX_W'(1);
            w_complete = (WORDS == 1);
          end else begin
            w_wr_slot  = r_idx;
            w_idx_next = r_idx + IDX_W'(1);
            w_complete = (r_idx == LAST_IDX);
          end
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          w_load       = 1'b1;
          w_state_next = ST_HUNT;
        end
      end
      default: begin
        w_state_next = ST_HUNT;
        w_idx_next   = '0;
      end
    endcase

    if (w_complete) begin
      w_idx_next = '0;
      if (w_out_free) begin
        w_load       = 1'b1;
        w_state_next = ST_HUNT;
      end else begin
        w_state_next = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        if (w_hit[k]) begin
          r_buf[k] <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid   <= 1'b0;
      r_m_latent  <= '0;
      r_err_sync  <= 1'b0;
      r_err_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_load) begin
        r_m_valid  <= 1'b1;
        r_m_latent <= w_frame;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end

      if (r_m_valid && m_ready) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_err_sync <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_latent  = r_m_latent;
  assign err_sync  = r_err_sync;
  assign err_cnt   = r_err_cnt;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_hgcal_latent_rx.sv
// Scoreboard bench for hgcal_latent_rx. A second instance with WORDS==1
// covers the single-word frame path and the frame_cnt wrap.
module tb_hgcal_latent_rx;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_sof;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_latent;
  logic        err_sync;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  logic        t2_s_valid;
  logic        t2_s_ready;
  logic [7:0]  t2_s_data;
  logic        t2_s_sof;
  logic        t2_m_valid;
  logic        t2_m_ready;
  logic [7:0]  t2_m_latent;
  logic        t2_err_sync;
  logic [7:0]  t2_err_cnt;
  logic [15:0] t2_frame_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          err_hi = 0;
  int          stall_cnt = 0;
  bit          stream_on = 0;
  logic [31:0] exp_q[$];
  int          out_cyc_q[$];

  hgcal_latent_rx dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .m_valid(m_valid), .m_ready(m_ready),
    .m_latent(m_latent), .err_sync(err_sync), .err_cnt(err_cnt),
    .frame_cnt(frame_cnt)
  );

  hgcal_latent_rx #(.LATENT_N(4), .CODE_W(2), .LINK_W(8)) u_w1 (
    .clk(clk), .rst_n(rst_n), .s_valid(t2_s_valid), .s_ready(t2_s_ready),
    .s_data(t2_s_data), .s_sof(t2_s_sof), .m_valid(t2_m_valid),
    .m_ready(t2_m_ready), .m_latent(t2_m_latent), .err_sync(t2_err_sync),
    .err_cnt(t2_err_cnt), .frame_cnt(t2_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard on every m-side handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h, expected none", m_latent);
        end else begin
          chk("m_latent", m_latent, exp_q.pop_front());
        end
        out_cyc_q.push_back(cyc);
      end
      if (err_sync) err_hi++;
      if (stream_on && !s_ready) stall_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present one word and hold it until accepted; returns 1 time unit after
  // the accepting edge, so back-to-back calls leave no bubble.
  task automatic send(input logic sof, input logic [7:0] d);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_ready) break;
      if (t >= 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got s_ready=0, expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] w [4];
    int base;
    rst_n = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b0;
    t2_s_valid = 1'b0; t2_s_sof = 1'b0; t2_s_data = '0; t2_m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_latent", m_latent, 32'd0);
    chk("rst_err_sync", 32'(err_sync), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single frame
    m_ready = 1'b1;
    exp_q.push_back(32'hFF00E41B);
    send(1'b1, 8'h1B); send(1'b0, 8'hE4); send(1'b0, 8'h00); send(1'b0, 8'hFF);
    chk("single_latency_m_valid", 32'(m_valid), 32'd1);
    tick();
    chk("single_m_valid_cleared", 32'(m_valid), 32'd0);
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("single_err_cnt", 32'(err_cnt), 32'd0);

    // Sync loss
    send(1'b0, 8'h55);
    chk("stray_err_sync", 32'(err_sync), 32'd1);
    chk("stray_err_cnt", 32'(err_cnt), 32'd1);
    tick();
    chk("stray_err_sync_drop", 32'(err_sync), 32'd0);
    exp_q.push_back(32'h06050403);
    send(1'b1, 8'h01); send(1'b0, 8'h02);
    send(1'b1, 8'h03); send(1'b0, 8'h04); send(1'b0, 8'h05); send(1'b0, 8'h06);
    tick();
    chk("resync_err_cnt", 32'(err_cnt), 32'd2);
    chk("resync_frame_cnt", 32'(frame_cnt), 32'd2);

    // Back-pressure
    m_ready = 1'b0;
    base = 32'(frame_cnt);
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'hD4C3B2A1);
    exp_q.push_back(32'h8D7C6B5A);
    send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33); send(1'b0, 8'h44);
    send(1'b1, 8'hA1); send(1'b0, 8'hB2); send(1'b0, 8'hC3); send(1'b0, 8'hD4);
    chk("hold_s_ready", 32'(s_ready), 32'd0);
    chk("hold_m_valid", 32'(m_valid), 32'd1);
    chk("hold_m_latent_a", m_latent, 32'h44332211);
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_m_latent_a", m_latent, 32'h44332211);
    end
    m_ready = 1'b1;
    tick();
    chk("drain_a_frame_cnt", 32'(frame_cnt), 32'(base + 1));
    chk("drain_m_latent_b", m_latent, 32'hD4C3B2A1);
    chk("drain_s_ready", 32'(s_ready), 32'd1);
    send(1'b1, 8'h5A);
    chk("drain_b_frame_cnt", 32'(frame_cnt), 32'(base + 2));
    send(1'b0, 8'h6B); send(1'b0, 8'h7C); send(1'b0, 8'h8D);
    repeat (2) tick();

    // Streaming
    out_cyc_q.delete();
    stream_on = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) w[k] = 8'(f * 4 + k);
      exp_q.push_back({w[3], w[2], w[1], w[0]});
      send(1'b1, w[0]); send(1'b0, w[1]); send(1'b0, w[2]); send(1'b0, w[3]);
    end
    repeat (3) tick();
    stream_on = 1'b0;
    chk("stream_outputs", 32'(out_cyc_q.size()), 32'd100);
    for (int i = 1; i < out_cyc_q.size(); i++) begin
      chk("stream_spacing", 32'(out_cyc_q[i] - out_cyc_q[i-1]), 32'd4);
    end
    chk("stream_s_ready_stalls", 32'(stall_cnt), 32'd0);
    chk("stream_frame_cnt", 32'(frame_cnt), 32'(base + 103));

    // Reset mid-frame
    send(1'b1, 8'h21); send(1'b0, 8'h22); send(1'b0, 8'h23);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_latent", m_latent, 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(32'h34333231);
    send(1'b1, 8'h31); send(1'b0, 8'h32); send(1'b0, 8'h33); send(1'b0, 8'h34);
    tick();
    chk("postrst_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("postrst_err_cnt", 32'(err_cnt), 32'd0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(1'b0, 8'(i));
    repeat (2) tick();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("err_sync_cycles", 32'(err_hi), 32'd302);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // frame_cnt wrap on the single-word-frame instance
    t2_s_valid = 1'b1; t2_s_sof = 1'b1; t2_s_data = 8'hA5; t2_m_ready = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    chk("w1_frame_cnt_max", 32'(t2_frame_cnt), 32'hFFFF);
    chk("w1_m_latent", 32'(t2_m_latent), 32'hA5);
    chk("w1_s_ready", 32'(t2_s_ready), 32'd1);
    chk("w1_err_cnt", 32'(t2_err_cnt), 32'd0);
    tick();
    chk("w1_frame_cnt_wrap", 32'(t2_frame_cnt), 32'd0);
    t2_s_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hgcal_latent_rx.md
# hgcal_latent_rx

Receive end of the HGCAL autoencoder latent link. Accepts the packed quantized latent codes produced by the encoder LUT layers as a stream of narrow link words framed by a start-of-frame marker. Reassembles each frame into one full-width latent vector for the decoder LUT network. Handles frame synchronization, back-pressure in both directions and error accounting.

## Interface
Parameters:
- `LATENT_N`, default 16: number of latent codes per frame.
- `CODE_W`, default 2: bits per latent code.
- `LINK_W`, default 8: link word width. Must be a multiple of `CODE_W` and must divide `LATENT_N*CODE_W`.
- Derived `WORDS = LATENT_N*CODE_W/LINK_W`, default 4. Must be ≥ 1.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `s_valid`  in  1  — link word valid.
- `s_ready`  out  1  — link word accepted when `s_valid && s_ready` at a rising edge.
- `s_data`  in  `LINK_W`  — link word; code i of the word is at bits `[i*CODE_W +: CODE_W]`.
- `s_sof`  in  1  — marks word 0 of a frame; qualified by `s_valid`.
- `m_valid`  out  1  — latent vector valid.
- `m_ready`  in  1  — decoder accepts the vector.
- `m_latent`  out  `LATENT_N*CODE_W`  — word k is placed at bits `[k*LINK_W +: LINK_W]`.
- `err_sync`  out  1  — one-cycle pulse per sync error.
- `err_cnt`  out  8  — sync-error count, saturating.
- `frame_cnt`  out  16  — count of frames delivered on the m-side, wrapping.

## Operation
State machine:
- **HUNT**: waits for a word with `s_sof=1`.
- **COLLECT**: expects words 1..WORDS-1.
- **HOLD**: a complete frame sits in the collection buffer and the output register is still occupied.

Rules:
- `s_ready = (state != HOLD)`. It is combinational from state.
- **HUNT, accepted word with sof=1**: the word is stored at slot 0 and `idx` is set to 1. Next state is COLLECT; if `WORDS==1` the frame is complete instead.
- **HUNT, accepted word with sof=0**: the word is discarded, `err_sync` pulses and `err_cnt` increments. State stays HUNT.
- **COLLECT, accepted word with sof=0**: the word is stored at slot `idx` and `idx` increments.
- **COLLECT, accepted word with sof=1**: the partial frame is dropped, `err_sync` pulses and `err_cnt` increments. The new word is stored as slot 0, `idx` is set to 1, and the state stays COLLECT.
- **Frame complete** (the last word is accepted): if the output register is free (`!m_valid || m_ready` that cycle), the full buffer loads into `m_latent`, `m_valid` is set, and the state returns to HUNT. Otherwise the state goes to HOLD.
- **HOLD**: when `m_ready` is high, the buffer moves into the output register on that edge and the state returns to HUNT. `s_ready` re-asserts the next cycle.
- `m_valid` clears on `m_ready` when no new frame is loading in the same cycle.
- `m_latent` is stable while `m_valid && !m_ready`.
- `frame_cnt` increments on every m-side handshake (`m_valid && m_ready`) and wraps 0xFFFF→0.
- `err_cnt` saturates at 255.
- Unused bits of partially filled slots are don't-care; they are never exposed.

## Timing
- **Reset**: while `rst_n` is low, the state is HUNT and `idx=0`. `m_valid=0`, `m_latent=0`, `err_sync=0`, `err_cnt=0`, `frame_cnt=0`. `s_ready` reads 1, but no transfer is taken while reset is asserted.
- **Reset mid-frame**: the partial frame and any held vector are lost, with no error counted.
- **Latency**: the last word is accepted at edge t, and `m_valid=1` from edge t (visible in cycle t+1) when the output register is free.
- **Throughput**: one link word per cycle is sustained with no bubbles while `m_ready` is held high. Back-to-back frames produce `m_valid` every WORDS cycles.
- **Simultaneous events**: a frame completing in the same cycle the output is drained loads directly, with no HOLD cycle. In that cycle `frame_cnt` counts the drained vector.
- **Back-pressure**: with the output occupied, the decoder stalled, and a second frame complete, the block sits in HOLD with `s_ready=0`. At most two frames are buffered (output register plus collection buffer).

## Test plan
Default parameters are used throughout unless stated.
- **Single frame**: words {sof:0x1B, 0xE4, 0x00, 0xFF} on consecutive cycles with `m_ready=1` → `m_latent=32'hFF00E41B` and `m_valid` high for one cycle, starting the cycle after word 3. `frame_cnt=1`, no `err_sync`.
- **Sync loss**: a non-sof word 0x55 in HUNT → `err_sync` one-cycle pulse, `err_cnt=1`, no output. Then sof:0x01, 0x02, then sof:0x03, 0x04, 0x05, 0x06 → `err_cnt=2`, single output `32'h06050403`.
- **Back-pressure**: `m_ready=0` and two full frames A then B sent → A held on `m_latent`, B's last word accepted, then `s_ready=0` (HOLD). Raising `m_ready` → A, then B on the next cycle. `frame_cnt=2`, and the words of a third frame stall until after the drain.
- **Streaming**: 100 back-to-back frames with `m_ready=1` → 100 outputs, each matching its frame, spaced exactly 4 cycles apart. `s_ready` never deasserts.
- **Reset mid-frame**: after sof + 2 words, pulse `rst_n` low for 1 cycle between edges → all outputs return to zero immediately. The next complete frame is delivered correctly and `err_cnt` stays 0.
- **Saturation/wrap**: 300 stray non-sof words → `err_cnt=255`. Force 65536 frames (or preload via `$deposit` a `frame_cnt` of 0xFFFF and deliver one frame) → `frame_cnt` wraps to 0.
